multi_driver_cntrl: RTL

Parametrised multi-channel driver control/status register bank sitting between the AXI-lite slave adapter and NUM_CH independent address/vector FIFO pipelines. Each channel has its own program state machine, FIFO push port, thresholds and monitor histogram window. Shared logic provides a sticky, maskable interrupt and a trace-buffer read window with auto-incrementing address. Reads are registered with a valid strobe.

---
 rtl/multi_driver_cntrl_if.sv | 21 ++
 rtl/multi_driver_cntrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_driver_cntrl_if.sv
// Register-bus bundle between the AXI-lite slave adapter (master side) and
// the multi-channel driver control bank (slave side).
interface multi_driver_cntrl_if;
   logic [31:0] slave_awaddr;
   logic [31:0] slave_araddr;
   logic        slave_wr;
   logic        slave_rd;
   logic [31:0] slave_data_in;
   logic [31:0] slave_data_out;
   logic        slave_rd_valid;

   modport master (
      output slave_awaddr, slave_araddr, slave_wr, slave_rd, slave_data_in,
      input  slave_data_out, slave_rd_valid
   );

   modport slave (
      input  slave_awaddr, slave_araddr, slave_wr, slave_rd, slave_data_in,
      output slave_data_out, slave_rd_valid
   );
endinterface

// File: rtl/multi_driver_cntrl.sv
// Multi-channel driver control/status register bank: per-channel program FSM,
// FIFO push port, thresholds and monitor window, plus shared IRQ and trace window.
module multi_driver_cntrl #(
   parameter int NUM_CH    = 2,
   parameter int MON_BINS  = 16,
   parameter int MON_CNT_W = 16,
   parameter int TRACE_W   = 256
) (
   input  logic                                  clk,
   input  logic                                  reset,
   multi_driver_cntrl_if.slave                   bus,
   output logic [32*NUM_CH-1:0]                  addr_fifo_din,
   output logic [NUM_CH-1:0]                     addr_fifo_wr,
   input  logic [NUM_CH-1:0]                     addr_fifo_full,
   input  logic [NUM_CH-1:0]                     addr_fifo_overrun,
   input  logic [NUM_CH-1:0]                     addr_fifo_underrun,
   input  logic [NUM_CH-1:0]                     vector_fifo_overrun,
   input  logic [NUM_CH-1:0]                     vector_fifo_underrun,
   input  logic [16*NUM_CH-1:0]                  words_in_addr_fifo,
   input  logic [16*NUM_CH-1:0]                  words_in_vctr_fifo,
   output logic [16*NUM_CH-1:0]                  addr_fifo_threshold,
   output logic [16*NUM_CH-1:0]                  vector_fifo_threshold,
   input  logic [NUM_CH*MON_BINS*MON_CNT_W-1:0]  mon_cnts,
   output logic [31:0]                           trace_buf_bram_addr,
   input  logic [TRACE_W-1:0]                    trace_buf_bram_data,
   output logic [NUM_CH-1:0]                     active_program,
   output logic [NUM_CH-1:0]                     freeze_program,
   output logic [NUM_CH-1:0]                     end_program,
   output logic                                  irq
);

   localparam int TRACE_WORDS = TRACE_W / 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_FROZEN = 3'd2,
      ST_DONE   = 3'd3,
      ST_ERROR  = 3'd4
   } chState_t;

   logic [3:0]           w_wrRegion, w_rdRegion;
   logic [11:0]          w_wrOff, w_rdOff;
   logic                 w_gWr, w_start, w_traceInc;
   logic [31:0]          w_irqSet, w_w1c, w_rdData;
   logic [NUM_CH-1:0]    w_doneEvt, w_errEvt, w_dropEvt;
   logic [3*NUM_CH-1:0]  w_stateVec;
   logic [8*NUM_CH-1:0]  w_dropVec;
   logic                 w_unusedAddrBits;

   logic [31:0]          r_irqStatus, r_irqEnable, r_traceAddr, r_rdData;
   logic                 r_autoInc, r_irq, r_rdValid;

   assign w_wrRegion = bus.slave_awaddr[15:12];
   assign w_wrOff    = bus.slave_awaddr[11:0];
   assign w_rdRegion = bus.slave_araddr[15:12];
   assign w_rdOff    = bus.slave_araddr[11:0];
   // Address bits above the region field are don't-care.
   assign w_unusedAddrBits = ^{bus.slave_awaddr[31:16], bus.slave_araddr[31:16]};

   assign w_gWr   = bus.slave_wr && (w_wrRegion == 4'd0);
   assign w_start = w_gWr && (w_wrOff == 12'h000) && bus.slave_data_in[0];
   assign w_w1c   = (w_gWr && (w_wrOff == 12'h004)) ? bus.slave_data_in : 32'd0;
   assign w_irqSet = 32'(w_doneEvt) | (32'(w_errEvt) << 8) | (32'(w_dropEvt) << 16);
   assign w_traceInc = bus.slave_rd && r_autoInc && (w_rdRegion == 4'd0)
                     && (w_rdOff == 12'(32'h210 + 4*(TRACE_WORDS-1)));

   for (genvar g = 0; g < NUM_CH; g++) begin : gCh
      localparam logic [3:0] REGION = 4'(g + 1);

      chState_t    r_state, w_next;
      logic [4:0]  w_ctrl;
      logic        w_chWr, w_live, w_err, w_push, w_pushOk, w_runEvt, w_doneE, w_errE;
      logic [7:0]  r_dropCnt;
      logic [31:0] r_pushData;
      logic [15:0] r_addrThr, r_vecThr;
      logic        r_pushWr, r_active, r_freeze, r_end;

      assign w_chWr   = bus.slave_wr && (w_wrRegion == REGION);
      assign w_ctrl   = (w_chWr && (w_wrOff == 12'h004)) ? bus.slave_data_in[4:0] : 5'd0;
      assign w_live   = (r_state == ST_RUN) || (r_state == ST_FROZEN);
      assign w_err    = addr_fifo_overrun[g] | addr_fifo_underrun[g]
                      | vector_fifo_overrun[g] | vector_fifo_underrun[g];
      assign w_push   = w_chWr && (w_wrOff == 12'h000);
      assign w_pushOk = w_push && !addr_fifo_full[g] && (r_state != ST_ERROR);

      // Priority chain: abort > error > end > freeze set/clear > run/start.
      always_comb begin
         w_next   = r_state;
         w_runEvt = 1'b0;
         w_doneE  = 1'b0;
         w_errE   = 1'b0;
         if (w_ctrl[2]) begin
            w_next = ST_IDLE;
         end else if (w_live && w_err) begin
            w_next = ST_ERROR;
            w_errE = 1'b1;
         end else if (w_live && w_ctrl[1]) begin
            w_next  = ST_DONE;
            w_doneE = 1'b1;
         end else if ((r_state == ST_RUN) && w_ctrl[3]) begin
            w_next = ST_FROZEN;
         end else if ((r_state == ST_FROZEN) && w_ctrl[4]) begin
            w_next = ST_RUN;
         end else if (!w_live && (w_ctrl[0] || w_start)) begin
            w_next   = ST_RUN;
            w_runEvt = 1'b1;
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_state    <= ST_IDLE;
            r_active   <= 1'b0;
            r_freeze   <= 1'b0;
            r_end      <= 1'b0;
            r_pushWr   <= 1'b0;
            r_pushData <= 32'd0;
            r_dropCnt  <= 8'd0;
            r_addrThr  <= 16'd820;
            r_vecThr   <= 16'd7500;
         end else begin
            r_state  <= w_next;
            r_active <= (w_next == ST_RUN) || (w_next == ST_FROZEN);
            r_freeze <= (w_next == ST_FROZEN);
            r_end    <= w_doneE;
            r_pushWr <= w_pushOk;
            if (w_pushOk) begin
               r_pushData <= bus.slave_data_in;
            end
            if (w_runEvt) begin
               r_dropCnt <= 8'd0;
            end else if (w_push && !w_pushOk && (r_dropCnt != 8'hFF)) begin
               r_dropCnt <= r_dropCnt + 8'd1;
            end
            if (w_chWr && (w_wrOff == 12'h008)) begin
               r_addrThr <= bus.slave_data_in[15:0];
            end
            if (w_chWr && (w_wrOff == 12'h00C)) begin
               r_vecThr <= bus.slave_data_in[15:0];
            end
         end
      end

      assign w_doneEvt[g]                  = w_doneE;
      assign w_errEvt[g]                   = w_errE;
      assign w_dropEvt[g]                  = w_push && !w_pushOk;
      assign w_stateVec[3*g +: 3]          = r_state;
      assign w_dropVec[8*g +: 8]           = r_dropCnt;
      assign addr_fifo_din[32*g +: 32]     = r_pushData;
      assign addr_fifo_wr[g]               = r_pushWr;
      assign addr_fifo_threshold[16*g +: 16]   = r_addrThr;
      assign vector_fifo_threshold[16*g +: 16] = r_vecThr;
      assign active_program[g]             = r_active;
      assign freeze_program[g]             = r_freeze;
      assign end_program[g]                = r_end;
   end

   // Shared IRQ and trace-window registers; a set event beats its own W1C.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irqStatus <= 32'd0;
         r_irqEnable <= 32'd0;
         r_traceAddr <= 32'd0;
         r_autoInc   <= 1'b0;
         r_irq       <= 1'b0;
      end else begin
         r_irqStatus <= (r_irqStatus & ~w_w1c) | w_irqSet;
         r_irq       <= |(r_irqStatus & r_irqEnable);
         if (w_gWr && (w_wrOff == 12'h008)) begin
            r_irqEnable <= bus.slave_data_in;
         end
         if (w_gWr && (w_wrOff == 12'h200)) begin
            r_traceAddr <= bus.slave_data_in;
         end else if (w_traceInc) begin
            r_traceAddr <= r_traceAddr + 32'd1;
         end
         if (w_gWr && (w_wrOff == 12'h204)) begin
            r_autoInc <= bus.slave_data_in[0];
         end
      end
   end

   always_comb begin
      w_rdData = 32'd0;
      if (w_rdRegion == 4'd0) begin
         case (w_rdOff)
            12'h004: w_rdData = r_irqStatus;
            12'h008: w_rdData = r_irqEnable;
            12'h200: w_rdData = r_traceAddr;
            12'h204: w_rdData = {31'd0, r_autoInc};
            default: begin
               for (int k = 0; k < TRACE_WORDS; k++) begin
                  if (w_rdOff == 12'(32'h210 + 4*k)) begin
                     w_rdData = trace_buf_bram_data[32*k +: 32];
                  end
               end
            end
         endcase
      end else begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (w_rdRegion == 4'(ch + 1)) begin
               case (w_rdOff)
                  12'h000: w_rdData = addr_fifo_din[32*ch +: 32];
                  12'h008: w_rdData = {16'd0, addr_fifo_threshold[16*ch +: 16]};
                  12'h00C: w_rdData = {16'd0, vector_fifo_threshold[16*ch +: 16]};
                  12'h010: w_rdData = {16'd0, w_dropVec[8*ch +: 8], 3'd0,
                                       addr_fifo_full[ch], 1'b0, w_stateVec[3*ch +: 3]};
                  12'h014: w_rdData = {16'd0, words_in_addr_fifo[16*ch +: 16]};
                  12'h018: w_rdData = {16'd0, words_in_vctr_fifo[16*ch +: 16]};
                  default: begin
                     for (int i = 0; i < MON_BINS; i++) begin
                        if (w_rdOff == 12'(32'h100 + 4*i)) begin
                           w_rdData[MON_CNT_W-1:0] =
                              mon_cnts[(ch*MON_BINS + i)*MON_CNT_W +: MON_CNT_W];
                        end
                     end
                  end
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rdData  <= 32'd0;
         r_rdValid <= 1'b0;
      end else begin
         r_rdValid <= bus.slave_rd;
         if (bus.slave_rd) begin
            r_rdData <= w_rdData;
         end
      end
   end

   assign bus.slave_data_out   = r_rdData;
   assign bus.slave_rd_valid   = r_rdValid;
   assign trace_buf_bram_addr  = r_traceAddr;
   assign irq                  = r_irq;

endmodule
